// File: rtl/note_render_pkg.sv
// rtl/note_render_pkg.sv - colour codes, FSM states, snapshot layout and widths for the note field renderer
package note_render_pkg;

  localparam int X_W        = 8;
  localparam int Y_W        = 7;
  localparam int ROW_W      = 7;
  localparam int LANE_COL_W = 6;
  localparam int COLOR_W    = 3;

  typedef enum logic [COLOR_W-1:0] {
    BG       = 3'd0,
    DIVIDER  = 3'd1,
    HITLINE  = 3'd2,
    NOTE     = 3'd3,
    NOTE_HIT = 3'd4,
    BANNER   = 3'd5,
    FLASH    = 3'd7
  } color_e;

  typedef enum logic [1:0] {
    SNAP  = 2'd0,
    SCAN  = 2'd1,
    BLANK = 2'd2
  } state_e;

  // One frame's worth of chart-engine state, frozen at SNAP.
  typedef struct packed {
    logic [3:0][ROW_W-1:0] row;
    logic [3:0]            active;
    logic [3:0]            hit;
    logic [1:0]            phase;
    logic [3:0]            keys;
  } snap_t;

endpackage

// File: rtl/note_pixel_classify.sv
// rtl/note_pixel_classify.sv - combinational colour priority for one playfield pixel
// LANE_FLASH_EN: BG pixels in a lane whose key was held at SNAP become FLASH.
module note_pixel_classify
  import note_render_pkg::*;
#(
  parameter int LANE_WIDTH  = 40,
  parameter int NOTE_HEIGHT = 8,
  parameter int HIT_ROW     = 100,
  parameter int BANNER_TOP  = 40
) (
  input  logic [X_W-1:0]        x,
  input  logic [Y_W-1:0]        y,
  input  logic [1:0]            lane_idx,
  input  logic [LANE_COL_W-1:0] lane_col,
  input  snap_t                 snap,
  output logic [COLOR_W-1:0]    color
);

  logic [X_W-1:0] banner_lim;
  logic [7:0]     y_ext;
  logic [7:0]     row_ext;
  logic [7:0]     row_end;
  logic           in_banner;
  logic           in_note;
  logic           on_divider;
  color_e         base;

  // Banner shrinks by one lane per phase: READY covers 3 lanes, GO covers 1.
  always_comb begin
    banner_lim = '0;
    case (snap.phase)
      2'd0:    banner_lim = X_W'(3 * LANE_WIDTH);
      2'd1:    banner_lim = X_W'(2 * LANE_WIDTH);
      2'd2:    banner_lim = X_W'(LANE_WIDTH);
      default: banner_lim = '0;
    endcase
  end

  assign in_banner = (snap.phase != 2'd3)
                  && (y >= Y_W'(BANNER_TOP))
                  && (y <= Y_W'(BANNER_TOP + 7))
                  && (x < banner_lim);

  // 8-bit note extent so a note near the bottom clips instead of wrapping to row 0.
  assign y_ext   = {1'b0, y};
  assign row_ext = {1'b0, snap.row[lane_idx]};
  assign row_end = row_ext + 8'(NOTE_HEIGHT);

  assign on_divider = (lane_col == '0) || (lane_col == LANE_COL_W'(LANE_WIDTH - 1));
  assign in_note    = snap.active[lane_idx] && (y_ext >= row_ext) && (y_ext < row_end)
                   && !on_divider;

  always_comb begin
    base = BG;
    if (in_banner)                 base = BANNER;
    else if (in_note)              base = snap.hit[lane_idx] ? NOTE_HIT : NOTE;
    else if (y == Y_W'(HIT_ROW))   base = HITLINE;
    else if (on_divider)           base = DIVIDER;
  end

`ifdef LANE_FLASH_EN
  assign color = (base == BG && snap.keys[lane_idx]) ? FLASH : base;
`else
  logic unused_keys;
  assign unused_keys = ^snap.keys;
  assign color       = base;
`endif

endmodule

// File: rtl/note_field_renderer.sv
// rtl/note_field_renderer.sv - per-frame snapshot, raster scan and pixel stream to the frame-buffer writer
// LANE_FLASH_EN: enables lane key flash in the classifier.
module note_field_renderer
  import note_render_pkg::*;
#(
  parameter int VIRTUAL_PIXEL_WIDTH  = 160,
  parameter int VIRTUAL_PIXEL_HEIGHT = 120,
  parameter int LANE_WIDTH           = 40,
  parameter int NOTE_HEIGHT          = 8,
  parameter int HIT_ROW              = 100,
  parameter int BANNER_TOP           = 40,
  parameter int BLANK_CYCLES         = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [ROW_W-1:0]   note_row0,
  input  logic [ROW_W-1:0]   note_row1,
  input  logic [ROW_W-1:0]   note_row2,
  input  logic [ROW_W-1:0]   note_row3,
  input  logic               note_active0,
  input  logic               note_active1,
  input  logic               note_active2,
  input  logic               note_active3,
  input  logic               note_hit0,
  input  logic               note_hit1,
  input  logic               note_hit2,
  input  logic               note_hit3,
  input  logic [1:0]         visible_phase,
  input  logic [3:0]         lane_keys,
  input  logic               pix_ready,
  output logic               pix_valid,
  output logic [X_W-1:0]     pix_x,
  output logic [Y_W-1:0]     pix_y,
  output logic [COLOR_W-1:0] pix_color,
  output logic               frame_done
);

  localparam int BLANK_W = $clog2(BLANK_CYCLES + 1);

  state_e                state;
  state_e                state_nxt;
  snap_t                 snap_in;
  snap_t                 snap_s;
  snap_t                 cls_snap;
  logic [1:0]            lane_idx;
  logic [1:0]            idx_nxt;
  logic [LANE_COL_W-1:0] lane_col;
  logic [LANE_COL_W-1:0] col_nxt;
  logic [X_W-1:0]        x_nxt;
  logic [Y_W-1:0]        y_nxt;
  logic [BLANK_W-1:0]    blank_cnt;
  logic [COLOR_W-1:0]    cls_color;
  logic                  accept;
  logic                  last_pix;
  logic                  blank_done;

  always_comb begin
    snap_in        = '0;
    snap_in.row    = {note_row3, note_row2, note_row1, note_row0};
    snap_in.active = {note_active3, note_active2, note_active1, note_active0};
    snap_in.hit    = {note_hit3, note_hit2, note_hit1, note_hit0};
    snap_in.phase  = visible_phase;
    snap_in.keys   = lane_keys;
  end

  assign accept     = pix_valid && pix_ready;
  assign last_pix   = (pix_x == X_W'(VIRTUAL_PIXEL_WIDTH - 1))
                   && (pix_y == Y_W'(VIRTUAL_PIXEL_HEIGHT - 1));
  assign blank_done = (blank_cnt == BLANK_W'(BLANK_CYCLES - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= SNAP;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      SNAP:    state_nxt = SCAN;
      SCAN:    if (accept && last_pix) state_nxt = BLANK;
      BLANK:   if (blank_done) state_nxt = SNAP;
      default: state_nxt = SNAP;
    endcase
  end

  // Coordinates of the pixel to present next; (0,0) while in SNAP.
  always_comb begin
    x_nxt   = '0;
    y_nxt   = '0;
    idx_nxt = '0;
    col_nxt = '0;
    if (state == SCAN) begin
      if (pix_x == X_W'(VIRTUAL_PIXEL_WIDTH - 1)) begin
        x_nxt = '0;
        y_nxt = pix_y + 1'b1;
      end else begin
        x_nxt = pix_x + 1'b1;
        y_nxt = pix_y;
      end
      if (lane_col == LANE_COL_W'(LANE_WIDTH - 1)) begin
        col_nxt = '0;
        idx_nxt = lane_idx + 1'b1;
      end else begin
        col_nxt = lane_col + 1'b1;
        idx_nxt = lane_idx;
      end
    end
  end

  // The first pixel is classified from the live inputs being captured in SNAP.
  assign cls_snap = (state == SNAP) ? snap_in : snap_s;

  note_pixel_classify #(
    .LANE_WIDTH  (LANE_WIDTH),
    .NOTE_HEIGHT (NOTE_HEIGHT),
    .HIT_ROW     (HIT_ROW),
    .BANNER_TOP  (BANNER_TOP)
  ) u_classify (
    .x        (x_nxt),
    .y        (y_nxt),
    .lane_idx (idx_nxt),
    .lane_col (col_nxt),
    .snap     (cls_snap),
    .color    (cls_color)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pix_valid  <= 1'b0;
      pix_x      <= '0;
      pix_y      <= '0;
      pix_color  <= BG;
      frame_done <= 1'b0;
      lane_idx   <= '0;
      lane_col   <= '0;
      blank_cnt  <= '0;
      snap_s     <= '0;
    end else begin
      case (state)
        SNAP: begin
          snap_s    <= snap_in;
          pix_x     <= x_nxt;
          pix_y     <= y_nxt;
          lane_idx  <= idx_nxt;
          lane_col  <= col_nxt;
          pix_color <= cls_color;
          pix_valid <= 1'b1;
          blank_cnt <= '0;
        end
        SCAN: begin
          if (accept) begin
            if (last_pix) begin
              pix_valid  <= 1'b0;
              frame_done <= 1'b1;
            end else begin
              pix_x     <= x_nxt;
              pix_y     <= y_nxt;
              lane_idx  <= idx_nxt;
              lane_col  <= col_nxt;
              pix_color <= cls_color;
            end
          end
        end
        BLANK: begin
          blank_cnt <= blank_cnt + 1'b1;
          if (blank_done) frame_done <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_note_field_renderer.sv
// tb/tb_note_field_renderer.sv - randomized full-frame scoreboard against a behavioural playfield model
`timescale 1ns/1ps
module tb_note_field_renderer;

  localparam int W     = 160;
  localparam int H     = 120;
  localparam int LW    = 40;
  localparam int NPIX  = W * H;
  localparam int BLANK = 16;
`ifdef LANE_FLASH_EN
  localparam int FLASH_CODE = 7;
`else
  localparam int FLASH_CODE = 0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] note_row0, note_row1, note_row2, note_row3;
  logic       note_active0, note_active1, note_active2, note_active3;
  logic       note_hit0, note_hit1, note_hit2, note_hit3;
  logic [1:0] visible_phase;
  logic [3:0] lane_keys;
  logic       pix_ready;
  logic       pix_valid;
  logic [7:0] pix_x;
  logic [6:0] pix_y;
  logic [2:0] pix_color;
  logic       frame_done;

  int n_tests = 0;
  int n_fail  = 0;

  int       m_row [4];
  bit       m_act [4];
  bit       m_hit [4];
  int       m_phase;
  bit [3:0] m_keys;
  logic [2:0] fb [H][W];

  note_field_renderer dut (
    .clk(clk), .rst(rst),
    .note_row0(note_row0), .note_row1(note_row1), .note_row2(note_row2), .note_row3(note_row3),
    .note_active0(note_active0), .note_active1(note_active1),
    .note_active2(note_active2), .note_active3(note_active3),
    .note_hit0(note_hit0), .note_hit1(note_hit1), .note_hit2(note_hit2), .note_hit3(note_hit3),
    .visible_phase(visible_phase), .lane_keys(lane_keys), .pix_ready(pix_ready),
    .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y), .pix_color(pix_color),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Playfield drawn straight from the rules: lane by division, priority by ordered tests.
  function automatic int exp_color(input int x, input int y);
    int lane;
    int col;
    lane = x / LW;
    col  = x % LW;
    if (m_phase != 3 && y >= 40 && y <= 47 && x < (3 - m_phase) * LW) return 5;
    if (m_act[lane] && y >= m_row[lane] && y < m_row[lane] + 8 && col != 0 && col != LW - 1)
      return m_hit[lane] ? 4 : 3;
    if (y == 100) return 2;
    if (col == 0 || col == LW - 1) return 1;
    if (m_keys[lane]) return FLASH_CODE;
    return 0;
  endfunction

  task automatic apply_snapshot();
    note_row0 = 7'(m_row[0]); note_row1 = 7'(m_row[1]);
    note_row2 = 7'(m_row[2]); note_row3 = 7'(m_row[3]);
    note_active0 = m_act[0]; note_active1 = m_act[1];
    note_active2 = m_act[2]; note_active3 = m_act[3];
    note_hit0 = m_hit[0]; note_hit1 = m_hit[1]; note_hit2 = m_hit[2]; note_hit3 = m_hit[3];
    visible_phase = 2'(m_phase);
    lane_keys     = m_keys;
  endtask

  task automatic random_model();
    for (int l = 0; l < 4; l++) begin
      m_row[l] = int'($urandom_range(0, 127));
      m_act[l] = 1'($urandom_range(0, 1));
      m_hit[l] = 1'($urandom_range(0, 1));
    end
    m_phase = int'($urandom_range(0, 3));
    m_keys  = 4'($urandom_range(0, 15));
  endtask

  // Disturb the live inputs only; the model keeps the frame's snapshot.
  task automatic scramble_inputs();
    note_row0 = 7'($urandom); note_row1 = 7'($urandom);
    note_row2 = 7'($urandom); note_row3 = 7'($urandom);
    {note_active3, note_active2, note_active1, note_active0} = 4'b1111;
    {note_hit3, note_hit2, note_hit1, note_hit0} = 4'($urandom);
    lane_keys     = 4'($urandom);
    visible_phase = 2'd0;
  endtask

  task automatic run_frame(input int ready_pct, input int mid_at, input int npix);
    int n;
    int cyc;
    bit stall;
    logic [7:0] sx;
    logic [6:0] sy;
    logic [2:0] sc;
    n = 0; cyc = 0; stall = 1'b0;
    sx = '0; sy = '0; sc = '0;
    while (n < npix && cyc < 4 * NPIX) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) check_val("first_valid", 32'(pix_valid), 1);
      if (stall) begin
        check_val("stall_valid", 32'(pix_valid), 1);
        check_val("stall_x", 32'(pix_x), 32'(sx));
        check_val("stall_y", 32'(pix_y), 32'(sy));
        check_val("stall_color", 32'(pix_color), 32'(sc));
      end
      pix_ready = ($urandom_range(1, 100) <= ready_pct);
      if (pix_valid && pix_ready) begin
        check_val("pix_x", 32'(pix_x), n % W);
        check_val("pix_y", 32'(pix_y), n / W);
        check_val("pix_color", 32'(pix_color), exp_color(n % W, n / W));
        fb[n / W][n % W] = pix_color;
        n++;
        if (n == mid_at) scramble_inputs();
      end
      stall = pix_valid && !pix_ready;
      sx = pix_x; sy = pix_y; sc = pix_color;
    end
    if (n < npix) check_val("frame_timeout", n, npix);
  endtask

  task automatic check_blank();
    int hi;
    hi = 0;
    @(negedge clk);
    while (frame_done === 1'b1 && hi < 64) begin
      hi++;
      check_val("blank_valid", 32'(pix_valid), 0);
      @(negedge clk);
    end
    check_val("blank_len", hi, BLANK);
    check_val("snap_valid", 32'(pix_valid), 0);
  endtask

  initial begin
    rst = 1'b0;
    pix_ready = 1'b0;
    for (int l = 0; l < 4; l++) begin
      m_row[l] = 0; m_act[l] = 1'b0; m_hit[l] = 1'b0;
    end
    m_phase = 3;
    m_keys  = 4'b0000;
    apply_snapshot();
    repeat (3) @(negedge clk);
    check_val("rst_valid", 32'(pix_valid), 0);
    check_val("rst_x", 32'(pix_x), 0);
    check_val("rst_y", 32'(pix_y), 0);
    check_val("rst_color", 32'(pix_color), 0);
    check_val("rst_frame_done", 32'(frame_done), 0);
    rst = 1'b1;

    // Empty field, full-rate acceptance
    run_frame(100, -1, NPIX);
    check_val("f1_div_0_0", 32'(fb[0][0]), 1);
    check_val("f1_hitline_5_100", 32'(fb[100][5]), 2);
    check_val("f1_bg_5_50", 32'(fb[50][5]), 0);

    // Lane 2 note over the hit line, lane 0 note clipped at the bottom, SET banner, lane 1 key
    for (int l = 0; l < 4; l++) begin
      m_row[l] = int'($urandom_range(0, 127)); m_act[l] = 1'b0; m_hit[l] = 1'b0;
    end
    m_act[2] = 1'b1; m_row[2] = 96;
    m_act[0] = 1'b1; m_row[0] = 116;
    m_phase  = 1;
    m_keys   = 4'b0010;
    apply_snapshot();
    check_blank();
    run_frame(100, 3000, NPIX);
    check_val("note_81_96", 32'(fb[96][81]), 3);
    check_val("note_118_103", 32'(fb[103][118]), 3);
    check_val("note_over_hitline", 32'(fb[100][100]), 3);
    check_val("div_80_98", 32'(fb[98][80]), 1);
    check_val("div_119_98", 32'(fb[98][119]), 1);
    check_val("clip_10_116", 32'(fb[116][10]), 3);
    check_val("clip_10_119", 32'(fb[119][10]), 3);
    check_val("nowrap_10_0", 32'(fb[0][10]), 0);
    check_val("nowrap_10_3", 32'(fb[3][10]), 0);
    check_val("banner_0_40", 32'(fb[40][0]), 5);
    check_val("banner_79_47", 32'(fb[47][79]), 5);
    check_val("banner_edge_80_40", 32'(fb[40][80]), 1);
    check_val("snapshot_held_120_40", 32'(fb[40][120]), 1);
    check_val("hitline_60_100", 32'(fb[100][60]), 2);
    check_val("flash_45_10", 32'(fb[10][45]), FLASH_CODE);

    // Partial frame interrupted by an asynchronous reset
    random_model();
    apply_snapshot();
    check_blank();
    run_frame(60, -1, 700);
    #2 rst = 1'b0;
    #1;
    check_val("midrst_valid", 32'(pix_valid), 0);
    check_val("midrst_x", 32'(pix_x), 0);
    check_val("midrst_y", 32'(pix_y), 0);
    check_val("midrst_color", 32'(pix_color), 0);
    check_val("midrst_frame_done", 32'(frame_done), 0);
    @(negedge clk);
    random_model();
    apply_snapshot();
    rst = 1'b1;

    // Random snapshot with back-pressure
    run_frame(70, -1, NPIX);
    check_blank();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
